alu_req_arbiter: RTL and testbench

//  Shares one combinational 8-bit ALU among NUM_REQ requesters. Each requester offers an

---
 rtl/alu_req_arbiter.sv | 111 +++++++++++
 tb/tb_alu_req_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational 8-bit ALU among NUM_REQ requesters,
// with a single registered, ID-tagged valid/ready response stage.
//
// state | meaning
// EMPTY | no result held, rsp_valid low
// FULL  | result held in rsp_* registers, rsp_valid high
module alu_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ*8-1:0] req_a,
   input  logic [NUM_REQ*8-1:0] req_b,
   input  logic [NUM_REQ*4-1:0] req_sel,
   output logic [7:0]           alu_a,
   output logic [7:0]           alu_b,
   output logic [3:0]           alu_sel,
   input  logic [7:0]           alu_out,
   input  logic                 alu_carry,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [7:0]           rsp_data,
   output logic                 rsp_carry,
   output logic                 rsp_err,
   output logic [ID_W-1:0]      rsp_id
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   state_e          state_q;
   logic [ID_W-1:0] rr_ptr_q;
   logic [ID_W-1:0] rsp_id_q;
   logic [7:0]      rsp_data_q;
   logic            rsp_carry_q;
   logic            rsp_err_q;

   logic            can_accept;
   logic            gnt_found;
   logic [ID_W-1:0] gnt_idx;
   logic [ID_W:0]   scan;
   logic            accept;
   logic            div_zero;

   assign can_accept = (state_q == EMPTY) || rsp_ready;

   // Scan rr_ptr, rr_ptr+1, ... with wrap at NUM_REQ; first valid requester wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      scan      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (scan >= (ID_W+1)'(NUM_REQ))
            scan = scan - (ID_W+1)'(NUM_REQ);
         if (!gnt_found && req_valid[scan[ID_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = scan[ID_W-1:0];
         end
      end
   end

   // Holding reset low also blocks grants, so nothing is accepted during reset.
   assign accept = gnt_found && can_accept && reset;

   always_comb begin
      req_ready = '0;
      alu_a     = '0;
      alu_b     = '0;
      alu_sel   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (accept && gnt_idx == ID_W'(i)) begin
            req_ready[i] = 1'b1;
            alu_a        = req_a[8*i +: 8];
            alu_b        = req_b[8*i +: 8];
            alu_sel      = req_sel[4*i +: 4];
         end
      end
   end

   assign div_zero = (alu_sel == 4'b0011) && (alu_b == 8'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= EMPTY;
         rr_ptr_q    <= '0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         rsp_carry_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else if (accept) begin
         state_q     <= FULL;
         rsp_id_q    <= gnt_idx;
         rsp_err_q   <= div_zero;
         rsp_data_q  <= div_zero ? 8'hFF : alu_out;
         rsp_carry_q <= (alu_sel == 4'b0000) ? alu_carry : 1'b0;
         rr_ptr_q    <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
      end else if (rsp_ready) begin
         state_q <= EMPTY;
      end
   end

   assign rsp_valid = (state_q == FULL);
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_carry = rsp_carry_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: a reference ALU drives alu_out, and expected
// responses are queued at grant time and compared as the response register updates.
module tb_alu_req_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [15:0] req_sel;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [3:0]  alu_sel;
   logic [7:0]  alu_out;
   logic        alu_carry;
   logic [8:0]  alu_sum;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_data;
   logic        rsp_carry;
   logic        rsp_err;
   logic [1:0]  rsp_id;

   logic [7:0]  ra [4];
   logic [7:0]  rb [4];
   logic [3:0]  rs [4];

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
      logic       carry;
      logic       err;
   } rsp_t;

   rsp_t q[$];
   int   n_pass = 0;
   int   n_fail = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   alu_req_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sel   (req_sel),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_out   (alu_out),
      .alu_carry (alu_carry),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_carry (rsp_carry),
      .rsp_err   (rsp_err),
      .rsp_id    (rsp_id)
   );

   function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] s);
      logic [15:0] w;
      case (s)
         4'd0:    w = 16'(a) + 16'(b);
         4'd1:    w = 16'(a) - 16'(b);
         4'd2:    w = 16'(a) * 16'(b);
         4'd3:    w = (b == 8'd0) ? 16'd0 : 16'(a / b);
         4'd8:    w = 16'(a & b);
         4'd9:    w = 16'(a | b);
         4'd10:   w = 16'(a ^ b);
         default: w = 16'd0;
      endcase
      return w[7:0];
   endfunction

   assign alu_out   = alu_ref(alu_a, alu_b, alu_sel);
   assign alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
   assign alu_carry = alu_sum[8];

   always_comb begin
      req_a   = '0;
      req_b   = '0;
      req_sel = '0;
      for (int i = 0; i < 4; i++) begin
         req_a[8*i +: 8]   = ra[i];
         req_b[8*i +: 8]   = rb[i];
         req_sel[4*i +: 4] = rs[i];
      end
   end

   function automatic rsp_t model(input int g);
      rsp_t       r;
      logic [8:0] sum;
      sum     = {1'b0, ra[g]} + {1'b0, rb[g]};
      r.id    = 2'(g);
      r.err   = (rs[g] == 4'b0011) && (rb[g] == 8'd0);
      r.data  = r.err ? 8'hFF : alu_ref(ra[g], rb[g], rs[g]);
      r.carry = (rs[g] == 4'b0000) ? sum[8] : 1'b0;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] s);
      ra[i] = a;
      rb[i] = b;
      rs[i] = s;
   endtask

   // One clock cycle: check the grant, queue the expected result, clock, check response.
   task automatic cyc(input logic [3:0] exp_rdy);
      int   g;
      bit   cons;
      rsp_t e;
      #1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      cons = (q.size() > 0) && rsp_ready;
      if (exp_rdy != 4'b0000) begin
         g = 0;
         for (int i = 0; i < 4; i++)
            if (exp_rdy[i]) g = i;
         q.push_back(model(g));
      end
      @(posedge clk);
      #1;
      if (cons) void'(q.pop_front());
      chk("rsp_valid", 32'(rsp_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
         e = q[0];
         chk("rsp_id",    32'(rsp_id),    32'(e.id));
         chk("rsp_data",  32'(rsp_data),  32'(e.data));
         chk("rsp_carry", 32'(rsp_carry), 32'(e.carry));
         chk("rsp_err",   32'(rsp_err),   32'(e.err));
      end
   endtask

   initial begin
      reset     = 1'b0;
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) set_op(i, 8'(i + 1), 8'd1, 4'd0);
      #2;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data",  32'(rsp_data),  32'd0);
      chk("rst_rsp_carry", 32'(rsp_carry), 32'd0);
      chk("rst_rsp_err",   32'(rsp_err),   32'd0);
      chk("rst_rsp_id",    32'(rsp_id),    32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset     = 1'b1;
      req_valid = 4'b0000;

      // Single add with carry out
      set_op(0, 8'd200, 8'd100, 4'b0000);
      req_valid = 4'b0001;
      rsp_ready = 1'b1;
      #1;
      chk("t1_alu_a",   32'(alu_a),   32'd200);
      chk("t1_alu_b",   32'(alu_b),   32'd100);
      chk("t1_alu_sel", 32'(alu_sel), 32'd0);
      cyc(4'b0001);
      chk("t1_data",  32'(rsp_data),  32'd44);
      chk("t1_carry", 32'(rsp_carry), 32'd1);
      req_valid = 4'b0000;
      cyc(4'b0000);

      // Divide by zero, normal divide, carry masked for non-add
      set_op(2, 8'd9, 8'd0, 4'b0011);
      req_valid = 4'b0100;
      cyc(4'b0100);
      chk("t4_err_flag", 32'(rsp_err),  32'd1);
      chk("t4_err_data", 32'(rsp_data), 32'hFF);
      set_op(2, 8'd9, 8'd2, 4'b0011);
      cyc(4'b0100);
      chk("t4_div_data", 32'(rsp_data), 32'd4);
      chk("t4_div_err",  32'(rsp_err),  32'd0);
      set_op(1, 8'd200, 8'd100, 4'b0001);
      req_valid = 4'b0010;
      cyc(4'b0010);
      chk("t4_carry_mask", 32'(rsp_carry), 32'd0);
      req_valid = 4'b0000;
      cyc(4'b0000);

      // Backpressure: response held, no grants, then release
      rsp_ready = 1'b0;
      set_op(0, 8'd5, 8'd7, 4'b0000);
      req_valid = 4'b0001;
      cyc(4'b0001);
      set_op(1, 8'd11, 8'd3, 4'd2);
      set_op(3, 8'hF0, 8'h0F, 4'd9);
      req_valid = 4'b1010;
      repeat (3) begin
         cyc(4'b0000);
         chk("t3_alu_a_idle", 32'(alu_a), 32'd0);
      end
      rsp_ready = 1'b1;
      cyc(4'b0010);
      req_valid = 4'b1000;
      cyc(4'b1000);

      // Wrap: after req3 granted, req1 goes before req3
      set_op(1, 8'd8, 8'd3, 4'd1);
      set_op(3, 8'd6, 8'd6, 4'd10);
      req_valid = 4'b1010;
      cyc(4'b0010);
      req_valid = 4'b1000;
      cyc(4'b1000);
      req_valid = 4'b0000;
      cyc(4'b0000);

      // Async reset drops a pending result without a clock edge
      rsp_ready = 1'b0;
      set_op(2, 8'd1, 8'd1, 4'd0);
      req_valid = 4'b0100;
      cyc(4'b0100);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t6_rsp_data",  32'(rsp_data),  32'd0);
      chk("t6_req_ready", 32'(req_ready), 32'd0);
      q.delete();
      req_valid = 4'b1111;
      @(posedge clk);
      #1;
      reset = 1'b1;

      // All requesters busy: 0,1,2,3,0 at one result per cycle
      rsp_ready = 1'b1;
      set_op(0, 8'd10, 8'd20, 4'd0);
      set_op(1, 8'd50, 8'd8,  4'd1);
      set_op(2, 8'd7,  8'd9,  4'd2);
      set_op(3, 8'hAA, 8'h0F, 4'd8);
      cyc(4'b0001);
      set_op(0, 8'd250, 8'd10, 4'd0);
      cyc(4'b0010);
      set_op(1, 8'd100, 8'd7, 4'd3);
      cyc(4'b0100);
      set_op(2, 8'h3C, 8'h5A, 4'd10);
      cyc(4'b1000);
      set_op(3, 8'd1, 8'd2, 4'd9);
      cyc(4'b0001);
      req_valid = 4'b0000;
      cyc(4'b0000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
